stg5mo: RTL and testbench

//  Pipeline stage 5 (memory operation), directly downstream of the memory-address stage.
//  The upstream stage drives the access address onto memory port ow_mem_mp (ping-pong 0/1) one cycle earlier.

---
 rtl/stg5mo.sv | 153 +++++++++++++++
 tb/tb_stg5mo.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/stg5mo.sv
// Stage 5 (memory operation): completes the access whose address stage 4 issued.
// Stores drive write-enables/data; loads capture read data; a bounded wait aborts.
`ifndef SIZE_ADDR
`define SIZE_ADDR 32
`endif
`ifndef SIZE_DATA
`define SIZE_DATA 32
`endif
`ifndef SIZE_OPC
`define SIZE_OPC 6
`endif
`ifndef SIZE_TGT_GP
`define SIZE_TGT_GP 4
`endif
`ifndef SIZE_TGT_SR
`define SIZE_TGT_SR 2
`endif
`ifndef OPC_R_LD
`define OPC_R_LD 6'h10
`endif
`ifndef OPC_R_ST
`define OPC_R_ST 6'h11
`endif
`ifndef OPC_I_STi
`define OPC_I_STi 6'h12
`endif
`ifndef OPC_IS_STis
`define OPC_IS_STis 6'h13
`endif

module stg5mo #(
    parameter logic [7:0] WAIT_MAX = 8'd8
) (
    input  logic                    iw_clk,
    input  logic                    iw_rst,
    input  logic [`SIZE_ADDR-1:0]   iw_pc,
    input  logic [`SIZE_DATA-1:0]   iw_instr,
    input  logic [`SIZE_OPC-1:0]    iw_opc,
    input  logic [`SIZE_TGT_GP-1:0] iw_tgt_gp,
    input  logic                    iw_tgt_gp_we,
    input  logic [`SIZE_TGT_SR-1:0] iw_tgt_sr,
    input  logic                    iw_tgt_sr_we,
    input  logic                    iw_mem_mp,
    input  logic [`SIZE_DATA-1:0]   iw_result,
    input  logic [1:0]              iw_mem_rdy,
    input  logic [`SIZE_DATA-1:0]   iw_mem_rdata0,
    input  logic [`SIZE_DATA-1:0]   iw_mem_rdata1,
    output logic [1:0]              ow_mem_we,
    output logic [`SIZE_DATA-1:0]   ow_mem_wdata,
    output logic                    ow_stall,
    output logic                    ow_mem_err,
    output logic [`SIZE_ADDR-1:0]   ow_pc,
    output logic [`SIZE_DATA-1:0]   ow_instr,
    output logic [`SIZE_OPC-1:0]    ow_opc,
    output logic [`SIZE_TGT_GP-1:0] ow_tgt_gp,
    output logic                    ow_tgt_gp_we,
    output logic [`SIZE_TGT_SR-1:0] ow_tgt_sr,
    output logic                    ow_tgt_sr_we,
    output logic [`SIZE_DATA-1:0]   ow_result
);

    localparam logic S_RUN  = 1'b0;
    localparam logic S_WAIT = 1'b1;

    logic                    state_q, state_d;
    logic [7:0]              wcnt_q, wcnt_d;
    logic                    err_q;
    logic [`SIZE_ADDR-1:0]   pc_q;
    logic [`SIZE_DATA-1:0]   instr_q;
    logic [`SIZE_OPC-1:0]    opc_q;
    logic [`SIZE_TGT_GP-1:0] gp_q;
    logic                    gp_we_q;
    logic [`SIZE_TGT_SR-1:0] sr_q;
    logic                    sr_we_q;
    logic [`SIZE_DATA-1:0]   result_q, result_d;

    logic is_ld, is_st, is_mem;
    logic p, rdy;
    logic done, abort, wait_more;

    assign is_ld  = (iw_opc == `OPC_R_LD);
    assign is_st  = (iw_opc == `OPC_R_ST) || (iw_opc == `OPC_I_STi)
                 || (iw_opc == `OPC_IS_STis);
    assign is_mem = is_ld | is_st;
    assign p      = iw_mem_mp;
    assign rdy    = iw_mem_rdy[p];

    // done: the instruction held on the inputs leaves this stage at the next edge
    assign done      = !is_mem || rdy;
    assign abort     = (state_q == S_WAIT) && !done && (wcnt_q == WAIT_MAX);
    assign wait_more = !done && !abort;

    assign ow_stall     = !iw_rst && ((state_q == S_WAIT) || !done);
    assign ow_mem_we    = (!iw_rst && is_st && rdy) ? {p, !p} : 2'b00;
    assign ow_mem_wdata = iw_result;

    assign result_d = is_ld ? (p ? iw_mem_rdata1 : iw_mem_rdata0) : iw_result;

    always_comb begin
        state_d = S_RUN;
        wcnt_d  = 8'd0;
        if (wait_more) begin
            state_d = S_WAIT;
            wcnt_d  = (state_q == S_RUN) ? 8'd1 : wcnt_q + 8'd1;
        end
    end

    always_ff @(posedge iw_clk or posedge iw_rst) begin
        if (iw_rst) begin
            state_q  <= S_RUN;
            wcnt_q   <= 8'd0;
            err_q    <= 1'b0;
            pc_q     <= '0;
            instr_q  <= '0;
            opc_q    <= '0;
            gp_q     <= '0;
            gp_we_q  <= 1'b0;
            sr_q     <= '0;
            sr_we_q  <= 1'b0;
            result_q <= '0;
        end else begin
            state_q <= state_d;
            wcnt_q  <= wcnt_d;
            err_q   <= abort;
            if (done) begin
                pc_q     <= iw_pc;
                instr_q  <= iw_instr;
                opc_q    <= iw_opc;
                gp_q     <= iw_tgt_gp;
                gp_we_q  <= iw_tgt_gp_we;
                sr_q     <= iw_tgt_sr;
                sr_we_q  <= iw_tgt_sr_we;
                result_q <= result_d;
            end else begin
                // bubble toward writeback; remaining fields hold
                opc_q   <= '0;
                gp_we_q <= 1'b0;
                sr_we_q <= 1'b0;
            end
        end
    end

    assign ow_mem_err   = err_q;
    assign ow_pc        = pc_q;
    assign ow_instr     = instr_q;
    assign ow_opc       = opc_q;
    assign ow_tgt_gp    = gp_q;
    assign ow_tgt_gp_we = gp_we_q;
    assign ow_tgt_sr    = sr_q;
    assign ow_tgt_sr_we = sr_we_q;
    assign ow_result    = result_q;

endmodule

// File: tb/tb_stg5mo.sv
// Scoreboard bench for stg5mo: stimulus pushes expected stores, writeback
// records and error pulses; a negedge monitor pops and compares them.
`ifndef SIZE_ADDR
`define SIZE_ADDR 32
`endif
`ifndef SIZE_DATA
`define SIZE_DATA 32
`endif
`ifndef SIZE_OPC
`define SIZE_OPC 6
`endif
`ifndef SIZE_TGT_GP
`define SIZE_TGT_GP 4
`endif
`ifndef SIZE_TGT_SR
`define SIZE_TGT_SR 2
`endif
`ifndef OPC_R_LD
`define OPC_R_LD 6'h10
`endif
`ifndef OPC_R_ST
`define OPC_R_ST 6'h11
`endif
`ifndef OPC_I_STi
`define OPC_I_STi 6'h12
`endif
`ifndef OPC_IS_STis
`define OPC_IS_STis 6'h13
`endif

module tb_stg5mo;

    localparam logic [5:0] ALU = 6'h01;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [5:0]  opc;
        logic [3:0]  gp;
        logic        gpwe;
        logic [1:0]  sr;
        logic        srwe;
        logic [31:0] res;
    } rec_t;

    logic        clk = 1'b0;
    logic        iw_rst;
    logic [31:0] iw_pc, iw_instr, iw_result, iw_mem_rdata0, iw_mem_rdata1;
    logic [5:0]  iw_opc;
    logic [3:0]  iw_tgt_gp;
    logic        iw_tgt_gp_we, iw_tgt_sr_we, iw_mem_mp;
    logic [1:0]  iw_tgt_sr, iw_mem_rdy;
    logic [1:0]  ow_mem_we;
    logic [31:0] ow_mem_wdata, ow_pc, ow_instr, ow_result;
    logic        ow_stall, ow_mem_err, ow_tgt_gp_we, ow_tgt_sr_we;
    logic [5:0]  ow_opc;
    logic [3:0]  ow_tgt_gp;
    logic [1:0]  ow_tgt_sr;

    rec_t        out_q[$];
    logic [33:0] st_q[$];
    int          err_pend = 0;
    int          n_cmp = 0;
    int          n_bad = 0;

    stg5mo #(.WAIT_MAX(8'd8)) dut (
        .iw_clk(clk), .iw_rst(iw_rst),
        .iw_pc(iw_pc), .iw_instr(iw_instr), .iw_opc(iw_opc),
        .iw_tgt_gp(iw_tgt_gp), .iw_tgt_gp_we(iw_tgt_gp_we),
        .iw_tgt_sr(iw_tgt_sr), .iw_tgt_sr_we(iw_tgt_sr_we),
        .iw_mem_mp(iw_mem_mp), .iw_result(iw_result),
        .iw_mem_rdy(iw_mem_rdy),
        .iw_mem_rdata0(iw_mem_rdata0), .iw_mem_rdata1(iw_mem_rdata1),
        .ow_mem_we(ow_mem_we), .ow_mem_wdata(ow_mem_wdata),
        .ow_stall(ow_stall), .ow_mem_err(ow_mem_err),
        .ow_pc(ow_pc), .ow_instr(ow_instr), .ow_opc(ow_opc),
        .ow_tgt_gp(ow_tgt_gp), .ow_tgt_gp_we(ow_tgt_gp_we),
        .ow_tgt_sr(ow_tgt_sr), .ow_tgt_sr_we(ow_tgt_sr_we),
        .ow_result(ow_result)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [127:0] act,
                       input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic unexpected(input string nm, input logic [127:0] act);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: unexpected output %h, nothing expected", nm, act);
    endtask

    function automatic rec_t mk(input logic [31:0] pc, input logic [5:0] opc,
                                input logic [3:0] gp, input logic gpwe,
                                input logic [31:0] res);
        rec_t r;
        r.pc    = pc;
        r.instr = pc ^ 32'hFFFF_0000;
        r.opc   = opc;
        r.gp    = gp;
        r.gpwe  = gpwe;
        r.sr    = 2'd2;
        r.srwe  = gpwe;
        r.res   = res;
        return r;
    endfunction

    always @(negedge clk) begin
        if (!iw_rst) begin
            if (ow_mem_we != 2'b00) begin
                if (st_q.size() == 0)
                    unexpected("store", 128'({ow_mem_we, ow_mem_wdata}));
                else
                    chk("store", 128'({ow_mem_we, ow_mem_wdata}),
                        128'(st_q.pop_front()));
            end
            if (ow_opc != 6'h00) begin
                rec_t a;
                a = '{ow_pc, ow_instr, ow_opc, ow_tgt_gp, ow_tgt_gp_we,
                      ow_tgt_sr, ow_tgt_sr_we, ow_result};
                if (out_q.size() == 0)
                    unexpected("writeback", 128'(a));
                else
                    chk("writeback", 128'(a), 128'(out_q.pop_front()));
            end
            if (ow_mem_err) begin
                chk("mem_err pending", 128'(err_pend != 0), 128'(1));
                if (err_pend > 0) err_pend--;
            end
        end
    end

    task automatic idle();
        iw_opc       = 6'h00;
        iw_tgt_gp_we = 1'b0;
        iw_tgt_sr_we = 1'b0;
        iw_mem_rdy   = 2'b00;
        iw_mem_mp    = 1'b0;
    endtask

    task automatic setin(input logic [5:0] opc, input logic mp,
                         input logic [31:0] pc, res, rd0, rd1,
                         input logic [3:0] gp, input logic gpwe);
        iw_opc        = opc;
        iw_mem_mp     = mp;
        iw_pc         = pc;
        iw_instr      = pc ^ 32'hFFFF_0000;
        iw_result     = res;
        iw_mem_rdata0 = rd0;
        iw_mem_rdata1 = rd1;
        iw_tgt_gp     = gp;
        iw_tgt_gp_we  = gpwe;
        iw_tgt_sr     = 2'd2;
        iw_tgt_sr_we  = gpwe;
    endtask

    // Called just after a rising edge; rdy goes to rdyf after nwait cycles.
    task automatic issue(input string nm, input logic [5:0] opc,
                         input logic mp, input logic [31:0] pc, res, rd0, rd1,
                         input logic [3:0] gp, input logic gpwe,
                         input int nwait, input logic [1:0] rdyf,
                         input int exp_stall);
        int stalls;
        int last;
        setin(opc, mp, pc, res, rd0, rd1, gp, gpwe);
        iw_mem_rdy = (nwait == 0) ? rdyf : 2'b00;
        last   = (exp_stall == 0) ? 0 : exp_stall - 1;
        stalls = 0;
        for (int c = 0; c <= last; c++) begin
            @(negedge clk);
            if (ow_stall) stalls++;
            @(posedge clk);
            #1;
            if (c + 1 == nwait) iw_mem_rdy = rdyf;
        end
        idle();
        chk({nm, " stall cycles"}, 128'(stalls), 128'(exp_stall));
    endtask

    initial begin
        iw_rst = 1'b1;
        setin(`OPC_R_ST, 1'b0, 32'h0, 32'h77, 32'h0, 32'h0, 4'd0, 1'b0);
        iw_mem_rdy = 2'b00;
        #2;
        chk("reset stall", 128'(ow_stall), 128'(0));
        iw_mem_rdy = 2'b01;
        #1;
        chk("reset mem_we", 128'(ow_mem_we), 128'(0));
        chk("reset regs",
            128'({ow_pc, ow_instr, ow_opc, ow_tgt_gp, ow_tgt_gp_we,
                  ow_tgt_sr, ow_tgt_sr_we, ow_result, ow_mem_err}), 128'(0));
        idle();
        #9;
        iw_rst = 1'b0;
        @(posedge clk);
        #1;

        out_q.push_back(mk(32'h100, ALU, 4'd3, 1'b1, 32'h1234));
        issue("alu", ALU, 1'b0, 32'h100, 32'h1234, 32'h0, 32'h0,
              4'd3, 1'b1, 0, 2'b00, 0);

        st_q.push_back({2'b10, 32'hDEAD});
        out_q.push_back(mk(32'h104, `OPC_R_ST, 4'd0, 1'b0, 32'hDEAD));
        issue("st p1", `OPC_R_ST, 1'b1, 32'h104, 32'hDEAD, 32'h0, 32'h0,
              4'd0, 1'b0, 0, 2'b10, 0);

        out_q.push_back(mk(32'h108, `OPC_R_LD, 4'd5, 1'b1, 32'hBEEF));
        issue("ld wait3", `OPC_R_LD, 1'b0, 32'h108, 32'h9999, 32'hBEEF,
              32'h5555, 4'd5, 1'b1, 3, 2'b01, 4);

        err_pend++;
        issue("sti timeout", `OPC_I_STi, 1'b0, 32'h10C, 32'hAAAA, 32'h0,
              32'h0, 4'd0, 1'b0, 0, 2'b00, 9);

        err_pend++;
        issue("ld wrong port", `OPC_R_LD, 1'b1, 32'h110, 32'h0, 32'hBAD0,
              32'h4444, 4'd6, 1'b1, 0, 2'b01, 9);

        st_q.push_back({2'b10, 32'hC0FE});
        out_q.push_back(mk(32'h114, `OPC_I_STi, 4'd0, 1'b0, 32'hC0FE));
        issue("sti wait2", `OPC_I_STi, 1'b1, 32'h114, 32'hC0FE, 32'h0,
              32'h0, 4'd0, 1'b0, 2, 2'b10, 3);

        st_q.push_back({2'b01, 32'h5A5A});
        out_q.push_back(mk(32'h118, `OPC_IS_STis, 4'd0, 1'b0, 32'h5A5A));
        issue("stis both rdy", `OPC_IS_STis, 1'b0, 32'h118, 32'h5A5A,
              32'h0, 32'h0, 4'd0, 1'b0, 0, 2'b11, 0);

        out_q.push_back(mk(32'h11C, `OPC_R_LD, 4'd7, 1'b1, 32'h1111));
        issue("ld p1", `OPC_R_LD, 1'b1, 32'h11C, 32'h0, 32'h2222,
              32'h1111, 4'd7, 1'b1, 0, 2'b10, 0);

        // store stuck in the wait state, then reset mid-wait
        setin(`OPC_R_ST, 1'b0, 32'h200, 32'hFEED, 32'h0, 32'h0, 4'd1, 1'b0);
        iw_mem_rdy = 2'b00;
        @(negedge clk);
        @(posedge clk);
        #1;
        @(negedge clk);
        @(posedge clk);
        #1;
        iw_rst     = 1'b1;
        iw_mem_rdy = 2'b01;
        #1;
        chk("mid-wait reset stall/we", 128'({ow_stall, ow_mem_we}), 128'(0));
        chk("mid-wait reset regs",
            128'({ow_pc, ow_instr, ow_opc, ow_tgt_gp, ow_tgt_gp_we,
                  ow_tgt_sr, ow_tgt_sr_we, ow_result, ow_mem_err}), 128'(0));
        @(posedge clk);
        #1;
        idle();
        @(negedge clk);
        #2;
        iw_rst = 1'b0;
        @(posedge clk);
        #1;

        out_q.push_back(mk(32'h300, ALU, 4'd9, 1'b1, 32'h0BAD_F00D));
        issue("alu after reset", ALU, 1'b0, 32'h300, 32'h0BAD_F00D, 32'h0,
              32'h0, 4'd9, 1'b1, 0, 2'b00, 0);

        repeat (4) @(posedge clk);
        #1;
        chk("writebacks left", 128'(out_q.size()), 128'(0));
        chk("stores left", 128'(st_q.size()), 128'(0));
        chk("errors left", 128'(err_pend), 128'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
